prog_loader: RTL and testbench

//  Parametrised program loader for the gpu instruction store. Accepts a word stream over a

---
 rtl/gpu_pkg.sv | 14 +
 rtl/prog_loader_csum.sv | 43 ++++
 rtl/prog_loader.sv | 155 +++++++++++++++
 tb/tb_prog_loader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared definitions for the gpu program loader: state encoding and default sizes.
package gpu_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_DATA_DEPTH = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } load_state_e;

endpackage

// File: rtl/prog_loader_csum.sv
// Running checksum of accepted program words with a sticky mismatch flag.
// Only built when PROG_LOADER_CSUM_EN is defined.
`ifdef PROG_LOADER_CSUM_EN
module prog_loader_csum
    import gpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  acc_en,
    input  logic                  check,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [DATA_WIDTH-1:0] exp,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  err
);

    logic [DATA_WIDTH-1:0] exp_q;

    // clear doubles as the sample point for the expected value
    always_ff @(posedge clk) begin
        if (reset) begin
            sum   <= '0;
            err   <= 1'b0;
            exp_q <= '0;
        end else if (clear) begin
            sum   <= '0;
            err   <= 1'b0;
            exp_q <= exp;
        end else begin
            if (acc_en) begin
                sum <= sum + data;
            end
            if (check && (sum != exp_q)) begin
                err <= 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/prog_loader.sv
// Streams a program into the gpu instruction store from address 0 and zero/FILL_VALUE-pads
// the tail. Optional checksum ports/logic when PROG_LOADER_CSUM_EN is defined.
module prog_loader
    import gpu_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned            DATA_DEPTH = DEF_DATA_DEPTH,
    parameter logic [DATA_WIDTH-1:0]  FILL_VALUE = '0,
    localparam int unsigned           ADDR_W     = $clog2(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  prog_loading,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [ADDR_W:0]       word_count,
    output logic                  done,
`ifdef PROG_LOADER_CSUM_EN
    input  logic [DATA_WIDTH-1:0] csum_exp,
    output logic [DATA_WIDTH-1:0] csum,
    output logic                  csum_err,
`endif
    output logic                  overflow
);

    localparam int unsigned       CNT_W     = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DATA_DEPTH - 1);

    load_state_e           state, state_nxt;
    logic [ADDR_W-1:0]     addr, addr_nxt;
    logic [CNT_W-1:0]      count_nxt;
    logic                  we_nxt;
    logic [ADDR_W-1:0]     waddr_nxt;
    logic [DATA_WIDTH-1:0] wdata_nxt;
    logic                  ovf_nxt;
    logic                  loading_nxt;
    logic                  done_nxt;
    logic                  accept_c;
    logic                  at_end_c;

    assign in_ready = (state == LOAD);
    assign accept_c = in_valid && in_ready;
    assign at_end_c = (addr == LAST_ADDR);

    // Next-state and next-output logic; addr saturates at LAST_ADDR so it never wraps
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        count_nxt = word_count;
        we_nxt    = 1'b0;
        waddr_nxt = mem_addr;
        wdata_nxt = mem_wdata;
        ovf_nxt   = overflow;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                    addr_nxt  = '0;
                    count_nxt = '0;
                    ovf_nxt   = 1'b0;
                end
            end
            LOAD: begin
                if (accept_c) begin
                    we_nxt    = 1'b1;
                    waddr_nxt = addr;
                    wdata_nxt = in_data;
                    count_nxt = word_count + CNT_W'(1);
                    if (at_end_c) begin
                        state_nxt = DONE;
                        ovf_nxt   = !in_last;
                    end else begin
                        addr_nxt = addr + ADDR_W'(1);
                        if (in_last) begin
                            state_nxt = FILL;
                        end
                    end
                end
            end
            FILL: begin
                we_nxt    = 1'b1;
                waddr_nxt = addr;
                wdata_nxt = FILL_VALUE;
                if (at_end_c) begin
                    state_nxt = DONE;
                end else begin
                    addr_nxt = addr + ADDR_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        loading_nxt = (state_nxt != IDLE);
        done_nxt    = (state_nxt == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            addr         <= '0;
            word_count   <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            overflow     <= 1'b0;
            prog_loading <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            addr         <= addr_nxt;
            word_count   <= count_nxt;
            mem_we       <= we_nxt;
            mem_addr     <= waddr_nxt;
            mem_wdata    <= wdata_nxt;
            overflow     <= ovf_nxt;
            prog_loading <= loading_nxt;
            done         <= done_nxt;
        end
    end

`ifdef PROG_LOADER_CSUM_EN
    logic csum_clear_c;
    logic csum_check_c;

    assign csum_clear_c = start && (state == IDLE);
    assign csum_check_c = (state == DONE);

    prog_loader_csum #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_csum (
        .clk    (clk),
        .reset  (reset),
        .clear  (csum_clear_c),
        .acc_en (accept_c),
        .check  (csum_check_c),
        .data   (in_data),
        .exp    (csum_exp),
        .sum    (csum),
        .err    (csum_err)
    );
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: vector table of whole loads plus hand-written
// reset/start corner cases; memory writes are checked against a scoreboard queue.
module tb_prog_loader;
    import gpu_pkg::*;

    localparam int unsigned DW    = DEF_DATA_WIDTH;
    localparam int unsigned DEPTH = DEF_DATA_DEPTH;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [DW-1:0] FILL = 16'hA5A5;

    logic          clk;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          prog_loading;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [AW:0]   word_count;
    logic          done;
    logic          overflow;
`ifdef PROG_LOADER_CSUM_EN
    logic [DW-1:0] csum_exp;
    logic [DW-1:0] csum;
    logic          csum_err;
`endif

    prog_loader #(
        .DATA_WIDTH (DW),
        .DATA_DEPTH (DEPTH),
        .FILL_VALUE (FILL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .prog_loading (prog_loading),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .word_count   (word_count),
        .done         (done),
`ifdef PROG_LOADER_CSUM_EN
        .csum_exp     (csum_exp),
        .csum         (csum),
        .csum_err     (csum_err),
`endif
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        string name;
        int    n_words;
        bit    with_last;
        int    gap_pct;
        int    mul;
        int    exp_count;
        bit    exp_ovf;
        int    exp_writes;
        int    img_op;     // 0 none, 1 snapshot image, 2 compare with snapshot
    } vec_t;

    wr_t           exp_q[$];
    logic [DW-1:0] image   [DEPTH];
    logic [DW-1:0] ref_img [DEPTH];
    int            checks = 0;
    int            errors = 0;
    int            done_cnt = 0;
    int            we_cnt = 0;
    int            cyc_cnt = 0;
    int            done_cyc = 0;
    int            last_we_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pattern(input int idx, input int mul);
        return DW'(idx * mul + 1);
    endfunction

    // Write monitor: every memory write must match the head of the scoreboard
    always @(negedge clk) begin
        cyc_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc_cnt;
            chk("loading_during_done", 64'(prog_loading), 64'd1);
        end
        if (mem_we) begin
            wr_t e;
            we_cnt++;
            last_we_cyc = cyc_cnt;
            image[mem_addr] = mem_wdata;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                         mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(mem_addr), 64'(e.addr));
                chk("wr_data", 64'(mem_wdata), 64'(e.data));
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_load(input vec_t v);
        int idx = 0;
        int cyc = 0;
        done_cnt = 0;
        we_cnt   = 0;
        pulse_start();
        while (idx < v.n_words && done_cnt == 0 && cyc < 5000) begin
            in_valid = ($urandom_range(99) >= v.gap_pct);
            in_data  = pattern(idx, v.mul);
            in_last  = v.with_last && (idx == v.n_words - 1);
            @(negedge clk);
            if (cyc == 0) chk({v.name, "_loading_on_start"}, 64'(prog_loading), 64'd1);
            if (!v.with_last && idx >= int'(DEPTH))
                chk({v.name, "_ready_low_after_full"}, 64'(in_ready), 64'd0);
            if (in_valid && in_ready) begin
                exp_q.push_back('{AW'(idx), in_data});
                if (in_last)
                    for (int a = idx + 1; a < int'(DEPTH); a++) exp_q.push_back('{AW'(a), FILL});
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        cyc = 0;
        while (prog_loading && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(negedge clk);
        chk({v.name, "_finished_in_time"}, 64'(cyc < 3000), 64'd1);
        chk({v.name, "_word_count"}, 64'(word_count), 64'(v.exp_count));
        chk({v.name, "_overflow"}, 64'(overflow), 64'(v.exp_ovf));
        chk({v.name, "_done_pulses"}, 64'(done_cnt), 64'd1);
        chk({v.name, "_write_count"}, 64'(we_cnt), 64'(v.exp_writes));
        chk({v.name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
        chk({v.name, "_done_after_last_write"}, 64'((done_cyc - last_we_cyc) inside {0, 1}), 64'd1);
        chk({v.name, "_idle_ready"}, 64'(in_ready), 64'd0);
        chk({v.name, "_idle_we"}, 64'(mem_we), 64'd0);
        exp_q.delete();
        if (v.img_op == 1) begin
            for (int a = 0; a < int'(DEPTH); a++) ref_img[a] = image[a];
        end else if (v.img_op == 2) begin
            int diff = 0;
            for (int a = 0; a < int'(DEPTH); a++) if (image[a] !== ref_img[a]) diff++;
            chk({v.name, "_image_match"}, 64'(diff), 64'd0);
        end
    endtask

    vec_t vecs[6];

    initial begin
        int idx;
        int cyc;
        vec_t v;
        vecs[0] = '{"load192",   192,  1'b1, 0,  37, 192,  1'b0, 1024, 0};
        vecs[1] = '{"exact_fit", 1024, 1'b1, 0,  53, 1024, 1'b0, 1024, 0};
        vecs[2] = '{"overflow",  1030, 1'b0, 0,  11, 1024, 1'b1, 1024, 0};
        vecs[3] = '{"gapless16", 16,   1'b1, 0,  97, 16,   1'b0, 1024, 1};
        vecs[4] = '{"gaps16",    16,   1'b1, 50, 97, 16,   1'b0, 1024, 2};
        vecs[5] = '{"single",    1,    1'b1, 30, 5,  1,    1'b0, 1024, 0};

        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
`ifdef PROG_LOADER_CSUM_EN
        csum_exp = '0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_loading", 64'(prog_loading), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_count", 64'(word_count), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        @(posedge clk); #1 reset = 1'b0;

        foreach (vecs[i]) run_load(vecs[i]);

        // Reset in the middle of a load, with a stray start pulse during LOAD
        done_cnt = 0;
        we_cnt   = 0;
        pulse_start();
        idx = 0;
        cyc = 0;
        while (idx < 50 && cyc < 500) begin
            in_valid = 1'b1;
            in_data  = pattern(idx, 7);
            in_last  = 1'b0;
            start    = (idx == 25);
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back('{AW'(idx), in_data});
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_words_fed", 64'(idx), 64'd50);
        chk("midrst_loading", 64'(prog_loading), 64'd0);
        chk("midrst_ready", 64'(in_ready), 64'd0);
        chk("midrst_we", 64'(mem_we), 64'd0);
        chk("midrst_done", 64'(done_cnt), 64'd0);
        chk("midrst_count", 64'(word_count), 64'd0);
        chk("midrst_writes", 64'(we_cnt), 64'd50);
        chk("midrst_sb_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        v = '{"reload_after_rst", 16, 1'b1, 20, 13, 16, 1'b0, 1024, 0};
        run_load(v);

`ifdef PROG_LOADER_CSUM_EN
        csum_exp = 16'h000A;
        v = '{"csum_ok", 4, 1'b1, 0, 1, 4, 1'b0, 1024, 0};
        run_load(v);
        chk("csum_ok_sum", 64'(csum), 64'h000A);
        chk("csum_ok_err", 64'(csum_err), 64'd0);
        csum_exp = 16'h000B;
        v.name = "csum_bad";
        run_load(v);
        chk("csum_bad_sum", 64'(csum), 64'h000A);
        chk("csum_bad_err", 64'(csum_err), 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected bench to finish");
        $fatal(1, "watchdog");
    end

endmodule
